glbl_ctrl: RTL and testbench
============================

// Module: glbl_ctrl
// PURPOSE
//  Synthesizable global-startup controller replacing the simulation-only glbl.
//  After reset it holds global set/reset (GSR/PRLD) and global tristate (GTS)
//  asserted for programmable cycle counts, then optionally waits for PLL lock.
//  It then flags startup complete. Top-level singleton; no data path.
// PARAMETERS
//  ROC_CYCLES  10  tb_clk cycles GSR/PRLD stay high after rstb drops (0 = none)
//  TOC_CYCLES  0   tb_clk cycles GTS stays high after the ROC phase (0 = none)
//  LOCK_WAIT   1   1: wait for synchronized pll_locked_i before RUN; 0: skip
//  CNT_W       16  phase counter width; ROC_CYCLES, TOC_CYCLES < 2**CNT_W
// PORTS
//  tb_clk          in   1  system clock; all logic on posedge
//  rstb            in   1  reset, synchronous, active-high
//  pll_locked_i    in   1  asynchronous aggregate PLL/MMCM lock
//  gsr_o           out  1  global set/reset, active-high
//  prld_o          out  1  global preload; identical to gsr_o
//  gts_o           out  1  global tristate, active-high
//  pll_lockg_o     out  1  pll_locked_i after 2-flop synchronizer
//  startup_done_o  out  1  high in RUN only
//  jtag_ctl_o      out  9  {tck,tdi,tms,trst,capture,reset,shift,update,runtest}; constant 0
// BEHAVIOUR
//  - Reset: rstb is sampled only on the tb_clk posedge.
//    State=RESET, counter=0, sync flops=0, gsr_o=prld_o=gts_o=1.
//    pll_lockg_o=0, startup_done_o=0.
//  - FSM states: RESET -> ROC -> TOC -> WAIT_LOCK -> RUN. All outputs are registered.
//    RESET: on the first edge with rstb=0, go to ROC and load counter=0.
//    ROC: gsr/prld/gts=1. Count cycles. After ROC_CYCLES cycles, go to TOC.
//      If ROC_CYCLES=0, ROC lasts 0 cycles.
//    TOC: gsr/prld=0, gts=1. After TOC_CYCLES cycles, go to WAIT_LOCK.
//      If TOC_CYCLES=0, TOC is bypassed.
//    WAIT_LOCK: gsr/prld/gts=0. Go to RUN when pll_lockg_o=1 or LOCK_WAIT=0.
//    RUN: startup_done_o=1. Stay in RUN until reset.
//  - Exact timing: gsr_o falls on the (ROC_CYCLES+1)th posedge after rstb is
//    first sampled low. With TOC_CYCLES=0, gts_o falls on that same edge.
//  - Lock loss in RUN is ignored: startup_done_o stays 1, and pll_lockg_o
//    still tracks the input.
//  - rstb reasserted in any state: next posedge forces the full reset values.
//  - Counter saturates and never wraps. Compares use >=.
//  - Reset priority over everything. No X on outputs after the first reset edge.
// STRUCTURE
//  - Shared package glbl_pkg:
//    enum state_t {RESET, ROC, TOC, WAIT_LOCK, RUN};
//    JTAG_TIEOFF = 9'h000.
//  - One sub-module: sync_2ff (2-flop synchronizer, reset to 0) for pll_locked_i.
//  - Rest is a single FSM plus counter in glbl_ctrl.
// TESTING
//  1. rstb=1 for 2 edges, then 0; defaults; pll_locked_i=1 ->
//     gsr_o=gts_o=1 for exactly 10 edges, both 0 on edge 11,
//     startup_done_o=1 by edge 12.
//  2. TOC_CYCLES=3 ->
//     gsr_o falls at edge 11, gts_o falls at edge 14, prld_o==gsr_o always.
//  3. pll_locked_i=0 until edge 20, then 1 ->
//     startup_done_o stays 0 until 2 sync edges plus 1 later (edge 23).
//  4. rstb pulsed high 1 cycle while in ROC at edge 5 ->
//     all outputs at reset values next edge; ROC restarts with a full 10 cycles.
//  5. ROC_CYCLES=0, TOC_CYCLES=0, LOCK_WAIT=0 ->
//     gsr_o=gts_o=0 on first edge after rstb low, startup_done_o=1 one edge later.
//  6. Throughout all runs, jtag_ctl_o==9'h000;
//     in RUN, dropping pll_locked_i does not clear startup_done_o.

Source files
------------

// File: rtl/glbl_pkg.sv
// ============================================================================
// Module  : glbl_pkg
// Brief   : Shared startup-controller types, JTAG tie-off and phase helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package glbl_pkg;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        ROC       = 3'd1,
        TOC       = 3'd2,
        WAIT_LOCK = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam logic [8:0] JTAG_TIEOFF = 9'h000;

    // GSR/PRLD are only held while reset-on-configuration is in progress.
    function automatic logic gsr_high(input state_t s);
        return (s == RESET) || (s == ROC);
    endfunction

    function automatic logic gts_high(input state_t s);
        return (s == RESET) || (s == ROC) || (s == TOC);
    endfunction

endpackage

`default_nettype wire

// File: rtl/glbl_ctrl_sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Brief   : Two-flop synchronizer for a single asynchronous level, reset to 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic tb_clk,
    input  logic rstb,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge tb_clk) begin
        if (rstb) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/glbl_ctrl.sv
// ============================================================================
// Module  : glbl_ctrl
// Brief   : Global startup controller sequencing GSR/PRLD, GTS and PLL lock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module glbl_ctrl
    import glbl_pkg::*;
#(
    parameter int ROC_CYCLES = 10,
    parameter int TOC_CYCLES = 0,
    parameter int LOCK_WAIT  = 1,
    parameter int CNT_W      = 16
) (
    input  logic       tb_clk,
    input  logic       rstb,
    input  logic       pll_locked_i,
    output logic       gsr_o,
    output logic       prld_o,
    output logic       gts_o,
    output logic       pll_lockg_o,
    output logic       startup_done_o,
    output logic [8:0] jtag_ctl_o
);

    // Zero-length phases are folded away at elaboration time.
    localparam state_t c_AFTER_ROC   = (TOC_CYCLES == 0) ? WAIT_LOCK : TOC;
    localparam state_t c_AFTER_RESET = (ROC_CYCLES == 0) ? c_AFTER_ROC : ROC;

    localparam logic [CNT_W:0] c_ROC_LIM = (CNT_W+1)'(ROC_CYCLES);
    localparam logic [CNT_W:0] c_TOC_LIM = (CNT_W+1)'(TOC_CYCLES);
    localparam logic [CNT_W:0] c_ONE     = (CNT_W+1)'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gsr;
    logic             r_gts;
    logic             r_done;

    logic             w_lockg;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_roc_end;
    logic             w_toc_end;
    logic             w_lock_ok;

    sync_2ff u_lock_sync (
        .tb_clk (tb_clk),
        .rstb   (rstb),
        .i_d    (pll_locked_i),
        .o_q    (w_lockg)
    );

    // The counter value before an edge is the number of completed phase cycles minus one.
    assign w_cnt_nxt = (&r_cnt) ? r_cnt : (r_cnt + CNT_W'(1));
    assign w_roc_end = ({1'b0, r_cnt} + c_ONE) >= c_ROC_LIM;
    assign w_toc_end = ({1'b0, r_cnt} + c_ONE) >= c_TOC_LIM;
    assign w_lock_ok = w_lockg || (LOCK_WAIT == 0);

    always_ff @(posedge tb_clk) begin
        if (rstb) begin
            r_state <= RESET;
            r_cnt   <= '0;
            r_gsr   <= 1'b1;
            r_gts   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                RESET: begin
                    r_state <= c_AFTER_RESET;
                    r_cnt   <= '0;
                    r_gsr   <= gsr_high(c_AFTER_RESET);
                    r_gts   <= gts_high(c_AFTER_RESET);
                end
                ROC: begin
                    if (w_roc_end) begin
                        r_state <= c_AFTER_ROC;
                        r_cnt   <= '0;
                        r_gsr   <= 1'b0;
                        r_gts   <= gts_high(c_AFTER_ROC);
                    end else begin
                        r_cnt   <= w_cnt_nxt;
                    end
                end
                TOC: begin
                    if (w_toc_end) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                        r_gts   <= 1'b0;
                    end else begin
                        r_cnt   <= w_cnt_nxt;
                    end
                end
                WAIT_LOCK: begin
                    if (w_lock_ok) begin
                        r_state <= RUN;
                        r_done  <= 1'b1;
                    end
                end
                RUN: begin
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= RESET;
                    r_cnt   <= '0;
                    r_gsr   <= 1'b1;
                    r_gts   <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign gsr_o          = r_gsr;
    assign prld_o         = r_gsr;
    assign gts_o          = r_gts;
    assign pll_lockg_o    = w_lockg;
    assign startup_done_o = r_done;
    assign jtag_ctl_o     = JTAG_TIEOFF;

endmodule

`default_nettype wire

// File: tb/tb_glbl_ctrl.sv
// ============================================================================
// Module  : tb_glbl_ctrl
// Brief   : Self-checking bench for glbl_ctrl across three parameter sets.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_glbl_ctrl;

    logic tb_clk = 1'b0;
    logic rstb = 1'b1;
    logic pll_locked_i = 1'b0;

    logic       gsr   [3];
    logic       prld  [3];
    logic       gts   [3];
    logic       lockg [3];
    logic       done  [3];
    logic [8:0] jtag  [3];

    // Configuration d: 0 = defaults, 1 = TOC of 3, 2 = no phases and no lock wait.
    int c_ROC [3] = '{10, 10, 0};
    int c_TOC [3] = '{0, 3, 0};
    int c_LW  [3] = '{1, 1, 0};

    int n_total = 0;
    int n_bad   = 0;

    int   m_k = 0;
    logic m_s1 = 1'b0;
    logic m_lockg = 1'b0;
    logic m_done [3] = '{1'b0, 1'b0, 1'b0};

    always #5 tb_clk = ~tb_clk;

    glbl_ctrl #(.ROC_CYCLES(10), .TOC_CYCLES(0), .LOCK_WAIT(1), .CNT_W(16)) u_dut0 (
        .tb_clk(tb_clk), .rstb(rstb), .pll_locked_i(pll_locked_i),
        .gsr_o(gsr[0]), .prld_o(prld[0]), .gts_o(gts[0]), .pll_lockg_o(lockg[0]),
        .startup_done_o(done[0]), .jtag_ctl_o(jtag[0]));

    glbl_ctrl #(.ROC_CYCLES(10), .TOC_CYCLES(3), .LOCK_WAIT(1), .CNT_W(16)) u_dut1 (
        .tb_clk(tb_clk), .rstb(rstb), .pll_locked_i(pll_locked_i),
        .gsr_o(gsr[1]), .prld_o(prld[1]), .gts_o(gts[1]), .pll_lockg_o(lockg[1]),
        .startup_done_o(done[1]), .jtag_ctl_o(jtag[1]));

    glbl_ctrl #(.ROC_CYCLES(0), .TOC_CYCLES(0), .LOCK_WAIT(0), .CNT_W(16)) u_dut2 (
        .tb_clk(tb_clk), .rstb(rstb), .pll_locked_i(pll_locked_i),
        .gsr_o(gsr[2]), .prld_o(prld[2]), .gts_o(gts[2]), .pll_lockg_o(lockg[2]),
        .startup_done_o(done[2]), .jtag_ctl_o(jtag[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Edge index at which GSR and GTS are first seen low after rstb is sampled low.
    function automatic int gsr_fall(input int d);
        return c_ROC[d] + 1;
    endfunction

    function automatic int gts_fall(input int d);
        return c_ROC[d] + 1 + c_TOC[d];
    endfunction

    task automatic model_edge();
        logic old_lockg;
        old_lockg = m_lockg;
        if (rstb) begin
            m_k     = 0;
            m_s1    = 1'b0;
            m_lockg = 1'b0;
            for (int d = 0; d < 3; d++) m_done[d] = 1'b0;
        end else begin
            if (m_k < 1000000) m_k = m_k + 1;
            for (int d = 0; d < 3; d++) begin
                if (m_k >= gts_fall(d) + 1 && (old_lockg || c_LW[d] == 0))
                    m_done[d] = 1'b1;
            end
            m_lockg = m_s1;
            m_s1    = pll_locked_i;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("gsr%0d", d),   32'(gsr[d]),   32'(m_k < gsr_fall(d)));
            chk($sformatf("prld%0d", d),  32'(prld[d]),  32'(m_k < gsr_fall(d)));
            chk($sformatf("gts%0d", d),   32'(gts[d]),   32'(m_k < gts_fall(d)));
            chk($sformatf("lockg%0d", d), 32'(lockg[d]), 32'(m_lockg));
            chk($sformatf("done%0d", d),  32'(done[d]),  32'(m_done[d]));
            chk($sformatf("jtag%0d", d),  32'(jtag[d]),  32'h0);
        end
    endtask

    task automatic cyc(input logic r, input logic l);
        rstb = r;
        pll_locked_i = l;
        @(posedge tb_clk);
        model_edge();
        @(negedge tb_clk);
        check_all();
    endtask

    initial begin
        logic r_lk;

        // Startup with lock present from the start.
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk("rst_gsr", 32'(gsr[0]), 32'h1);
        chk("rst_gts", 32'(gts[0]), 32'h1);
        chk("rst_done", 32'(done[0]), 32'h0);
        chk("rst_lockg", 32'(lockg[0]), 32'h0);
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 1'b1);
            if (i == 1) begin
                chk("zero_gsr_e1", 32'(gsr[2]), 32'h0);
                chk("zero_gts_e1", 32'(gts[2]), 32'h0);
                chk("zero_done_e1", 32'(done[2]), 32'h0);
            end
            if (i == 2) chk("zero_done_e2", 32'(done[2]), 32'h1);
            if (i == 10) begin
                chk("def_gsr_e10", 32'(gsr[0]), 32'h1);
                chk("def_gts_e10", 32'(gts[0]), 32'h1);
            end
            if (i == 11) begin
                chk("def_gsr_e11", 32'(gsr[0]), 32'h0);
                chk("def_gts_e11", 32'(gts[0]), 32'h0);
                chk("toc_gsr_e11", 32'(gsr[1]), 32'h0);
                chk("toc_gts_e11", 32'(gts[1]), 32'h1);
                chk("def_done_e11", 32'(done[0]), 32'h0);
            end
            if (i == 12) chk("def_done_e12", 32'(done[0]), 32'h1);
            if (i == 13) chk("toc_gts_e13", 32'(gts[1]), 32'h1);
            if (i == 14) chk("toc_gts_e14", 32'(gts[1]), 32'h0);
        end

        // Lock loss while running.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
        chk("run_lockloss_done", 32'(done[0]), 32'h1);
        chk("run_lockloss_lockg", 32'(lockg[0]), 32'h0);

        // Late lock: sampled low through edge 20, high from edge 21.
        cyc(1'b1, 1'b0);
        for (int i = 1; i <= 25; i++) begin
            cyc(1'b0, (i > 20) ? 1'b1 : 1'b0);
            if (i == 22) chk("late_done_e22", 32'(done[0]), 32'h0);
            if (i == 23) chk("late_done_e23", 32'(done[0]), 32'h1);
        end

        // Reset pulse inside ROC restarts the full ROC phase.
        cyc(1'b1, 1'b1);
        for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        chk("pulse_gsr", 32'(gsr[0]), 32'h1);
        chk("pulse_lockg", 32'(lockg[0]), 32'h0);
        chk("pulse_zero_gsr", 32'(gsr[2]), 32'h1);
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b0, 1'b1);
            if (i == 10) chk("pulse_gsr_e10", 32'(gsr[0]), 32'h1);
            if (i == 11) chk("pulse_gsr_e11", 32'(gsr[0]), 32'h0);
        end

        // Random reset pulses and lock toggling against the model.
        r_lk = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 8) r_lk = ~r_lk;
            cyc(($urandom_range(0, 199) < 3) ? 1'b1 : 1'b0, r_lk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
